// File: rtl/issue_pkg.sv
// Shared definitions for the dual-issue scheduler.
// Holds the issue-state encoding, register-file geometry, the multiplier
// countdown width, and the scoreboard lookup and slot readiness helpers
// used by the issue logic.
package issue_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_W     = 5;
    localparam int MUL_CNT_W = 4;

    typedef enum logic {
        PAIR  = 1'b0,
        SLOT1 = 1'b1
    } issue_state_t;

    // A register is pending only if it is not x0 and its scoreboard bit is set.
    function automatic logic sb_hit(input logic [NUM_REGS-1:0] busy,
                                    input logic [REG_W-1:0]    r);
        return (r != {REG_W{1'b0}}) && busy[r];
    endfunction

    // A slot can issue when it is valid, every operand it reads is not pending,
    // its destination is not pending, and a multiply also finds the unit free.
    function automatic logic slot_ok(input logic [NUM_REGS-1:0] busy,
                                     input logic                mul_free,
                                     input logic                valid,
                                     input logic [REG_W-1:0]    rs1,
                                     input logic [REG_W-1:0]    rs2,
                                     input logic [REG_W-1:0]    rd,
                                     input logic                has_rd,
                                     input logic                use_imm,
                                     input logic                is_mul);
        return valid
            && !sb_hit(busy, rs1)
            && !(sb_hit(busy, rs2) && !use_imm)
            && !(sb_hit(busy, rd) && has_rd)
            && !(is_mul && !mul_free);
    endfunction

endpackage

// File: rtl/mul_scoreboard.sv
// Pending-write tracker for the shared multi-cycle multiplier.
// Ports: clk/rst; set_en/set_rd mark a multiply granted this cycle;
// busy is the per-register pending vector (bit 0 is always 0); mul_free
// is high when no multiply is counting down; wb_valid/wb_rd form a
// one-cycle writeback pulse when the in-flight multiply completes.
module mul_scoreboard
    import issue_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_W-1:0]    set_rd,
    output logic [NUM_REGS-1:0] busy,
    output logic                mul_free,
    output logic                wb_valid,
    output logic [REG_W-1:0]    wb_rd
);

    logic [NUM_REGS-1:0]  busy_r;
    logic [NUM_REGS-1:0]  busy_nxt_s;
    logic [MUL_CNT_W-1:0] mul_cnt_r;
    logic [REG_W-1:0]     mul_rd_r;
    logic                 wb_valid_r;
    logic [REG_W-1:0]     wb_rd_r;
    logic                 last_s;

    // Countdown reaches zero on this edge: retire the in-flight multiply.
    assign last_s = (mul_cnt_r == {{(MUL_CNT_W-1){1'b0}}, 1'b1});

    // Next scoreboard: retire the finishing destination, then mark a new one.
    always_comb begin
        busy_nxt_s = busy_r;
        if (last_s) begin
            busy_nxt_s[mul_rd_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (set_en && (set_rd != {REG_W{1'b0}})) begin
            busy_nxt_s[set_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard, latency counter and writeback pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= {NUM_REGS{1'b0}};
            mul_cnt_r  <= {MUL_CNT_W{1'b0}};
            mul_rd_r   <= {REG_W{1'b0}};
            wb_valid_r <= 1'b0;
            wb_rd_r    <= {REG_W{1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            wb_valid_r <= last_s;
            wb_rd_r    <= last_s ? mul_rd_r : {REG_W{1'b0}};
            if (set_en) begin
                mul_cnt_r <= MUL_CNT_W'(MUL_LAT);
                mul_rd_r  <= set_rd;
            end else if (mul_cnt_r != {MUL_CNT_W{1'b0}}) begin
                mul_cnt_r <= mul_cnt_r - {{(MUL_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                mul_cnt_r <= mul_cnt_r;
            end
        end
    end

    assign busy     = busy_r;
    assign mul_free = (mul_cnt_r == {MUL_CNT_W{1'b0}});
    assign wb_valid = wb_valid_r;
    assign wb_rd    = wb_rd_r;

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order issue controller for a two-wide decode pair.
// Inputs: clk, rst (async, active high), flush, and per-slot decode fields
// (valid, rs1, rs2, rd, has_rd, use_imm, is_mul).
// Outputs: stall (combinational hold for decode), registered issue strobes
// iss_valid_0/1, multiplier start iss_mul/iss_mul_slot, multiplier
// writeback mul_wb_valid/mul_wb_rd, scoreboard sb_busy and the
// dual-issue cycle counter dual_issue_cnt.
module dual_issue_scheduler
    import issue_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                dec_valid_0,
    input  logic                dec_valid_1,
    input  logic [REG_W-1:0]    dec_rs1_0,
    input  logic [REG_W-1:0]    dec_rs1_1,
    input  logic [REG_W-1:0]    dec_rs2_0,
    input  logic [REG_W-1:0]    dec_rs2_1,
    input  logic [REG_W-1:0]    dec_rd_0,
    input  logic [REG_W-1:0]    dec_rd_1,
    input  logic                dec_has_rd_0,
    input  logic                dec_has_rd_1,
    input  logic                dec_use_imm_0,
    input  logic                dec_use_imm_1,
    input  logic                dec_is_mul_0,
    input  logic                dec_is_mul_1,
    output logic                stall,
    output logic                iss_valid_0,
    output logic                iss_valid_1,
    output logic                iss_mul,
    output logic                iss_mul_slot,
    output logic                mul_wb_valid,
    output logic [REG_W-1:0]    mul_wb_rd,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic [CNT_W-1:0]    dual_issue_cnt
);

    issue_state_t        state_r, state_nxt_s;
    logic [NUM_REGS-1:0] busy_s;
    logic                mul_free_s;
    logic                ok_0_s, ok_1_s, pair_conf_s;
    logic                grant_0_s, grant_1_s, stall_s;
    logic                mul_0_s, mul_1_s, set_en_s;
    logic [REG_W-1:0]    set_rd_s;
    logic                iss_valid_0_r, iss_valid_1_r, iss_mul_r, iss_mul_slot_r;
    logic [CNT_W-1:0]    dual_cnt_r;

    assign ok_0_s = slot_ok(busy_s, mul_free_s, dec_valid_0, dec_rs1_0, dec_rs2_0,
                            dec_rd_0, dec_has_rd_0, dec_use_imm_0, dec_is_mul_0);
    assign ok_1_s = slot_ok(busy_s, mul_free_s, dec_valid_1, dec_rs1_1, dec_rs2_1,
                            dec_rd_1, dec_has_rd_1, dec_use_imm_1, dec_is_mul_1);

    // Hazards inside the pair that force slot 1 into the following cycle.
    always_comb begin
        pair_conf_s = 1'b0;
        if (dec_has_rd_0 && (dec_rd_0 != {REG_W{1'b0}}) &&
            ((dec_rd_0 == dec_rs1_1) || (!dec_use_imm_1 && (dec_rd_0 == dec_rs2_1)))) begin
            pair_conf_s = 1'b1;
        end else if (dec_has_rd_0 && dec_has_rd_1 && (dec_rd_0 == dec_rd_1) &&
                     (dec_rd_0 != {REG_W{1'b0}})) begin
            pair_conf_s = 1'b1;
        end else if (dec_is_mul_0 && dec_is_mul_1) begin
            pair_conf_s = 1'b1;
        end else begin
            pair_conf_s = 1'b0;
        end
    end

    // Grant, stall and next-state decision.
    always_comb begin
        grant_0_s   = 1'b0;
        grant_1_s   = 1'b0;
        stall_s     = 1'b0;
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = PAIR;
        end else begin
            case (state_r)
                PAIR: begin
                    if (dec_valid_0) begin
                        grant_0_s = ok_0_s;
                        grant_1_s = ok_0_s && ok_1_s && !pair_conf_s;
                        if (!grant_0_s) begin
                            stall_s = 1'b1;
                        end else if (dec_valid_1 && !grant_1_s) begin
                            stall_s     = 1'b1;
                            state_nxt_s = SLOT1;
                        end else begin
                            stall_s = 1'b0;
                        end
                    end else begin
                        // Slot 0 absent: slot 1 stands alone.
                        grant_1_s = ok_1_s;
                        stall_s   = dec_valid_1 && !ok_1_s;
                    end
                end
                SLOT1: begin
                    grant_1_s = ok_1_s;
                    if (ok_1_s) begin
                        state_nxt_s = PAIR;
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = PAIR;
                end
            endcase
        end
    end

    assign mul_0_s  = grant_0_s && dec_is_mul_0;
    assign mul_1_s  = grant_1_s && dec_is_mul_1;
    assign set_en_s = mul_0_s || mul_1_s;
    assign set_rd_s = mul_0_s ? dec_rd_0 : dec_rd_1;

    mul_scoreboard #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en_s),
        .set_rd   (set_rd_s),
        .busy     (busy_s),
        .mul_free (mul_free_s),
        .wb_valid (mul_wb_valid),
        .wb_rd    (mul_wb_rd)
    );

    // State register and registered issue/statistics outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= PAIR;
            iss_valid_0_r  <= 1'b0;
            iss_valid_1_r  <= 1'b0;
            iss_mul_r      <= 1'b0;
            iss_mul_slot_r <= 1'b0;
            dual_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            iss_valid_0_r  <= grant_0_s;
            iss_valid_1_r  <= grant_1_s;
            iss_mul_r      <= set_en_s;
            iss_mul_slot_r <= !mul_0_s && mul_1_s;
            if (grant_0_s && grant_1_s) begin
                dual_cnt_r <= dual_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                dual_cnt_r <= dual_cnt_r;
            end
        end
    end

    assign stall          = stall_s;
    assign iss_valid_0    = iss_valid_0_r;
    assign iss_valid_1    = iss_valid_1_r;
    assign iss_mul        = iss_mul_r;
    assign iss_mul_slot   = iss_mul_slot_r;
    assign sb_busy        = busy_s;
    assign dual_issue_cnt = dual_cnt_r;

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
Issue-stage controller between dual_decode and the two execute lanes of the superscalar CPU. Each cycle it decides whether decoded slot 0, slot 1, both, or neither may issue, keeping issue in order. It tracks pending writes from the shared multi-cycle multiplier in a register scoreboard, and splits dependent pairs across two cycles. It drives the decode stall and reports dual-issue statistics.

Parameters:
MUL_LAT, 3, cycles the multiplier occupies from the issue decision to writeback; legal range 2 to 15.
CNT_W, 32, width of the dual-issue performance counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  kill the current decode pair; no grants this cycle.
dec_valid_0/1  in  1  decoded slot valid.
dec_rs1_0/1, dec_rs2_0/1, dec_rd_0/1  in  5  register indices.
dec_has_rd_0/1  in  1  slot writes rd.
dec_use_imm_0/1  in  1  rs2 is not read.
dec_is_mul_0/1  in  1  slot targets the shared multiplier.
stall  out  1  combinational; decode must hold its outputs.
iss_valid_0/1  out  1  registered; slot issued to its lane this cycle.
iss_mul  out  1  registered; multiplier started this cycle.
iss_mul_slot  out  1  registered; slot that owns the started multiply.
mul_wb_valid  out  1  registered one-cycle pulse; multiply writes back.
mul_wb_rd  out  5  registered; destination of that writeback.
sb_busy  out  32  registered scoreboard (bit n: xn pending); bit 0 always 0.
dual_issue_cnt  out  CNT_W  registered count of cycles with both slots granted; wraps.

Behaviour:
- Reset: all outputs 0, state PAIR, mul_cnt 0. Asserting reset mid-operation drops any in-flight multiply; no mul_wb pulse is produced.
- sb_hit(r): r != 0 and sb_busy[r].
- ok(s): dec_valid_s, and none of the following holds:
  - sb_hit(rs1);
  - sb_hit(rs2) when the slot does not use an immediate;
  - sb_hit(rd) when the slot has rd (WAW);
  - the slot is a multiply and mul_cnt != 0.
- State PAIR:
  - grant_0 = ok(0).
  - grant_1 = grant_0 and ok(1), and none of the following holds:
    - slot 0 has a nonzero rd and that rd equals rs1_1, or equals rs2_1 when slot 1 uses rs2 (intra-pair RAW);
    - slot 0 and slot 1 both have rd, and the rd values are equal and nonzero;
    - both slots are multiplies.
  - If grant_0 and grant_1 both hold, stall = 0.
  - If grant_0 holds and dec_valid_1 is set but not granted: stall = 1, next state SLOT1.
  - If grant_0 does not hold and dec_valid_0 is set: stall = 1, stay in PAIR.
  - If dec_valid_0 is 0, slot 1 is treated as slot 0 is absent: grant_1 = ok(1) and the pair checks are skipped.
- State SLOT1 (slot 0 already issued; decode is holding the pair):
  - grant_0 = 0 and grant_1 = ok(1).
  - If grant_1: stall = 0, next state PAIR. Otherwise stall = 1.
- Registered outputs: iss_valid_s is grant_s, delayed one cycle. iss_mul and iss_mul_slot are set when a granted slot is a multiply. dual_issue_cnt increments when both grants hold.
- Multiply granted in cycle T:
  - At the end of T, load mul_cnt with MUL_LAT and set sb_busy[rd] if rd != 0.
  - mul_cnt decrements each cycle while it is nonzero.
  - On the 1-to-0 transition, clear the sb bit; mul_wb_valid and mul_wb_rd are high for exactly one cycle, cycle T+MUL_LAT+1.
  - A dependent instruction or a new multiply can be granted in that same cycle.
- Flush:
  - Both grants are forced to 0; next state PAIR; stall = 0.
  - The scoreboard and mul_cnt are untouched, because older multiplies complete.
  - A flush in the same cycle as a writeback still produces the writeback.
- A set and a clear of the same sb bit in one cycle is impossible, because of the WAW check.

Decomposition:
- issue_pkg: state encoding (PAIR, SLOT1), NUM_REGS = 32, REG_W = 5, MUL_CNT_W = 4.
- One sub-module, mul_scoreboard, holding sb_busy, mul_cnt, mul_wb_valid and mul_wb_rd. Interface: set_en and set_rd in; busy, mul_free and the writeback signals out.

Test Plan:
- Independent pair (x1 = x2 + x3 and x4 = x5 + x6), repeated for 4 cycles -> both iss_valid_0 and iss_valid_1 high every cycle, stall 0, dual_issue_cnt = 4.
- Pair x1 = x2 + x3 then x5 = x1 + x4 -> cycle 1 iss_valid_0 = 1 only, stall = 1; cycle 2 iss_valid_1 = 1 only, stall 0; dual_issue_cnt unchanged.
- MUL_LAT = 3: mul x7 granted in cycle 0, then add x8 = x7 + x1 -> iss_mul high in cycle 1; sb_busy[7] high in cycles 1-3; mul_wb_valid with rd 7 in cycle 4; the add is granted in cycle 4 and iss_valid_0 is high in cycle 5.
- Two multiplies in one pair, rd 9 and rd 10 -> slot 0 is granted, slot 1 is stalled until mul_wb_valid, then issues via state SLOT1.
- Flush while in SLOT1 with a multiply in flight -> no grants, state PAIR, mul_wb_valid still pulses on schedule.
- rst asserted at mul_cnt = 2 -> sb_busy = 0 and no mul_wb_valid pulse; operands naming x0 never stall.
